// File: rtl/rangefinder_pkg.sv
// Shared types and limits for the multi-lane range finder.
// Optional feature macro: RANGEFINDER_COUNT_EN (per-lane sample counter).
package rangefinder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lane_state_t;

    localparam int MIN_WIDTH    = 2;
    localparam int MIN_CHANNELS = 1;
    localparam int MIN_CNT_W    = 1;

endpackage

// File: rtl/rangefinder_lane.sv
// One range-finder lane: min/max tracking FSM with registered outputs.
// Optional feature macro: RANGEFINDER_COUNT_EN (saturating sample counter).
module rangefinder_lane
    import rangefinder_pkg::*;
#(
    parameter int WIDTH = 16
`ifdef RANGEFINDER_COUNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sample,
    input  logic             valid,
    input  logic             go,
    input  logic             finish,
    output logic [WIDTH-1:0] range,
    output logic             range_valid,
`ifdef RANGEFINDER_COUNT_EN
    output logic [CNT_W-1:0] sample_count,
`endif
    output logic             debug_error
);

    lane_state_t      state, state_nxt;
    logic [WIDTH-1:0] min_q, min_nxt, min_m;
    logic [WIDTH-1:0] max_q, max_nxt, max_m;
    logic             seen_q, seen_nxt, seen_m;
    logic [WIDTH-1:0] range_q, range_nxt;
    logic             rv_q, rv_nxt;
    logic             err_q, err_nxt;
`ifdef RANGEFINDER_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_m;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_nxt;
`endif

    // Min/max with the current sample folded in; first sample seeds both.
    always_comb begin
        min_m  = min_q;
        max_m  = max_q;
        seen_m = seen_q | valid;
        if (valid) begin
            if (!seen_q || sample < min_q) min_m = sample;
            if (!seen_q || sample > max_q) max_m = sample;
        end
    end

`ifdef RANGEFINDER_COUNT_EN
    // Saturating count of valid samples including the current one.
    always_comb begin
        cnt_m = cnt_q;
        if (valid && cnt_q != CNT_MAX) cnt_m = cnt_q + 1'b1;
    end
`endif

    // Next-state and output decode for the IDLE/RUN protocol.
    always_comb begin
        state_nxt = state;
        min_nxt   = min_q;
        max_nxt   = max_q;
        seen_nxt  = seen_q;
        range_nxt = range_q;
        rv_nxt    = 1'b0;
        err_nxt   = err_q;
`ifdef RANGEFINDER_COUNT_EN
        cnt_nxt     = cnt_q;
        cnt_out_nxt = cnt_out_q;
`endif
        unique case (state)
            IDLE: begin
                if (go && !finish) begin
                    state_nxt = RUN;
                    err_nxt   = 1'b0;
                    seen_nxt  = valid;
                    if (valid) begin
                        min_nxt = sample;
                        max_nxt = sample;
                    end
`ifdef RANGEFINDER_COUNT_EN
                    cnt_nxt = CNT_W'(valid);
`endif
                end else if (finish) begin
                    err_nxt = 1'b1;
                end
            end
            RUN: begin
                min_nxt  = min_m;
                max_nxt  = max_m;
                seen_nxt = seen_m;
`ifdef RANGEFINDER_COUNT_EN
                cnt_nxt = cnt_m;
`endif
                if (go) err_nxt = 1'b1;
                if (finish) begin
                    state_nxt = IDLE;
                    rv_nxt    = 1'b1;
                    if (seen_m) begin
                        range_nxt = max_m - min_m;
                    end else begin
                        range_nxt = '0;
                        err_nxt   = 1'b1;
                    end
`ifdef RANGEFINDER_COUNT_EN
                    cnt_out_nxt = cnt_m;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane state and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            min_q   <= '0;
            max_q   <= '0;
            seen_q  <= 1'b0;
            range_q <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef RANGEFINDER_COUNT_EN
            cnt_q     <= '0;
            cnt_out_q <= '0;
`endif
        end else begin
            state   <= state_nxt;
            min_q   <= min_nxt;
            max_q   <= max_nxt;
            seen_q  <= seen_nxt;
            range_q <= range_nxt;
            rv_q    <= rv_nxt;
            err_q   <= err_nxt;
`ifdef RANGEFINDER_COUNT_EN
            cnt_q     <= cnt_nxt;
            cnt_out_q <= cnt_out_nxt;
`endif
        end
    end

    assign range       = range_q;
    assign range_valid = rv_q;
    assign debug_error = err_q;
`ifdef RANGEFINDER_COUNT_EN
    assign sample_count = cnt_out_q;
`endif

endmodule

// File: rtl/multi_rangefinder.sv
// Multi-channel range finder: CHANNELS independent lanes on flat buses.
// Optional feature macro: RANGEFINDER_COUNT_EN (adds sample_count port).
module multi_rangefinder
    import rangefinder_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid,
    input  logic [CHANNELS-1:0]       go,
    input  logic [CHANNELS-1:0]       finish,
    output logic [CHANNELS*WIDTH-1:0] range,
    output logic [CHANNELS-1:0]       range_valid,
`ifdef RANGEFINDER_COUNT_EN
    output logic [CHANNELS*CNT_W-1:0] sample_count,
`endif
    output logic [CHANNELS-1:0]       debug_error
);

    if (WIDTH < MIN_WIDTH) begin : g_bad_width
        $error("multi_rangefinder: WIDTH below minimum");
    end
    if (CHANNELS < MIN_CHANNELS) begin : g_bad_channels
        $error("multi_rangefinder: CHANNELS below minimum");
    end
    if (CNT_W < MIN_CNT_W) begin : g_bad_cnt_w
        $error("multi_rangefinder: CNT_W below minimum");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        rangefinder_lane #(
            .WIDTH (WIDTH)
`ifdef RANGEFINDER_COUNT_EN
            ,
            .CNT_W (CNT_W)
`endif
        ) u_lane (
            .clock        (clock),
            .reset_n      (reset_n),
            .sample       (data_in[i*WIDTH +: WIDTH]),
            .valid        (valid[i]),
            .go           (go[i]),
            .finish       (finish[i]),
            .range        (range[i*WIDTH +: WIDTH]),
            .range_valid  (range_valid[i]),
`ifdef RANGEFINDER_COUNT_EN
            .sample_count (sample_count[i*CNT_W +: CNT_W]),
`endif
            .debug_error  (debug_error[i])
        );
    end

endmodule
